sipo_frame_rx: RTL and testbench
================================

Name: sipo_frame_rx

Overview:
- Serial-in, parallel-out frame receiver. It is the downstream consumer of the team's PISO shifter.
- It samples an LSB-first bit stream framed by a start strobe and assembles N-bit words.
- Completed words go to a one-deep valid/ready output buffer, so shifting of the next frame continues while the consumer stalls.
- It flags aborted frames and overruns.

Parameters:
- N, 4, data word width in bits (N >= 2).
- CNT_W, $clog2(N+2), bit-counter width. Derived localparam, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, asynchronous, active-low.
- start  input  1  frame strobe; high in the transmitter's load cycle. The line carries 0 in that cycle.
- serial_in  input  1  serial data, LSB first; bit i is valid i+1 cycles after start.
- data_out  output  N  received word; stable while out_valid=1.
- out_valid  output  1  data_out holds an unconsumed word.
- out_ready  input  1  consumer accepts data_out when out_valid && out_ready at a clock edge.
- busy  output  1  high while in SHIFT.
- frame_abort  output  1  one-cycle pulse when start arrives mid-frame.
- overrun  output  1  one-cycle pulse when a completed word is dropped.
- parity_err  output  1  parity result for the word in data_out; tied 0 without the macro.

Behaviour:
- Reset (rst=0, asynchronous) clears all of the following to 0 and puts the FSM in IDLE:
  - data_out, out_valid, busy, frame_abort, overrun, parity_err;
  - shift register and bit counter.
- FSM states are IDLE and SHIFT.
  - IDLE -> SHIFT on start=1. The counter clears to 0. serial_in is ignored in that cycle.
  - SHIFT: each edge shifts serial_in in at the MSB (shreg <= {serial_in, shreg[N-1:1]}) and increments the counter. After FRAME_BITS samples (N, or N+1 with parity) the FSM commits and returns to IDLE.
- Commit:
  - If the output buffer is empty, or is being drained in the same edge (out_ready=1), data_out and parity_err load and out_valid=1.
  - Otherwise the new word is discarded, the old word is kept, and overrun pulses for 1 cycle.
- Latency: start at edge k, bits sampled at edges k+1..k+N. out_valid is high after edge k+N, i.e. in the cycle immediately after the last bit.
- start in SHIFT (including the final-bit cycle):
  - The partial frame is discarded and frame_abort pulses.
  - The counter restarts at 0 and the FSM stays in SHIFT.
  - No commit happens that cycle.
- start in the cycle right after a commit (FSM in IDLE): a normal new frame begins. Back-to-back frames are supported with a 1-cycle gap, matching the transmitter's load cycle.
- Handshake:
  - out_valid falls after an edge with out_ready=1 and no commit.
  - A simultaneous accept and commit keeps out_valid=1 with the new data.
  - out_ready while out_valid=0 has no effect.
- busy = (state==SHIFT), registered.
- Mid-operation reset aborts the frame and drops any buffered word; no pulses are generated.

Optional Feature:
- Macro: SIPO_PARITY_EN.
- Defined:
  - The frame is N+1 bits; the bit after data MSB is even parity over the N data bits.
  - That bit is sampled but not placed in data_out.
  - parity_err = XOR of the N data bits and the parity bit, latched with the word at commit and cleared at reset.
  - The latency to out_valid is N+1 cycles after start.
- Undefined:
  - The frame is N bits and parity_err is constant 0.

Decomposition:
- Package sipo_pkg:
  - state enum (ST_IDLE, ST_SHIFT);
  - localparam function for FRAME_BITS(N, parity_en);
  - the parity-mode constant.
- Sub-module sipo_out_buf: one-deep valid/ready register slice holding data_out and parity_err. It emits overrun when a write collides with a full, non-draining buffer.
- The FSM and shifter live in the top.

Test Plan (N=4):
- Basic frame: start at cycle 0, then serial 0,1,0,1 at cycles 1-4, out_ready=1 → data_out=4'hA, out_valid=1 in cycle 5 for one cycle, busy high in cycles 1-4.
- Back-to-back frames: 4'hA, 1-cycle gap, then 4'h3 with out_ready=1 → two words, A then 3, and no overrun.
- Stall and overrun: out_ready=0, send 4'h5 then 4'hC → data_out stays 5, overrun pulses 1 cycle at the second commit. Then raise out_ready → 5 is accepted and out_valid drops.
- Abort: start, 2 bits, start again, then 1,1,1,1 → frame_abort pulses once and data_out=4'hF, committed 4 cycles after the second start.
- Async reset: assert rst mid-frame and mid-stall (out_valid=1) → all outputs 0 immediately; a following clean frame 4'h9 is received correctly.
- With SIPO_PARITY_EN:
  - 4'hB with parity 1 → parity_err=0, out_valid in cycle 6;
  - same data with parity 0 → parity_err=1.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and frame-length helpers for the SIPO frame receiver.
// Parity mode follows the SIPO_PARITY_EN macro.
package sipo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

`ifdef SIPO_PARITY_EN
    localparam bit PARITY_EN = 1'b1;
`else
    localparam bit PARITY_EN = 1'b0;
`endif

    // Serial samples per frame: the data bits, plus one parity bit when enabled.
    function automatic int frame_bits(input int n, input bit parity_en);
        return parity_en ? n + 1 : n;
    endfunction

endpackage

// File: rtl/sipo_frame_rx_out_buf.sv
// One-deep valid/ready slice holding the received word and its parity flag.
// A write into a full buffer that is not draining this edge is dropped, and overrun pulses.
module sipo_out_buf #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [N-1:0] wr_data,
    input  logic         wr_perr,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         out_valid,
    output logic         parity_err,
    output logic         overrun
);

    logic [N-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         perr_q, perr_d;
    logic         ovr_q, ovr_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        perr_d  = perr_q;
        ovr_d   = 1'b0;
        if (wr_en && (!valid_q || out_ready)) begin
            data_d  = wr_data;
            perr_d  = wr_perr;
            valid_d = 1'b1;
        end else if (wr_en) begin
            ovr_d = 1'b1;
        end else if (valid_q && out_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            perr_q  <= perr_d;
            ovr_q   <= ovr_d;
        end
    end

    assign data_out   = data_q;
    assign out_valid  = valid_q;
    assign parity_err = perr_q;
    assign overrun    = ovr_q;

endmodule

// File: rtl/sipo_frame_rx.sv
// Serial-in parallel-out frame receiver: LSB-first bits after a start strobe build an N-bit word.
// Build with SIPO_PARITY_EN to take an extra even-parity bit per frame.
module sipo_frame_rx
    import sipo_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         serial_in,
    input  logic         out_ready,
    output logic [N-1:0] data_out,
    output logic         out_valid,
    output logic         busy,
    output logic         frame_abort,
    output logic         overrun,
    output logic         parity_err
);

    localparam int CNT_W = $clog2(N + 2);
    localparam int FB    = frame_bits(N, PARITY_EN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FB - 1);
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(N);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [N-1:0]     shreg_q, shreg_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;
    logic             commit;
    logic             wr_perr;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        abort_d = 1'b0;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SHIFT;
                    cnt_d   = '0;
                end
            end
            ST_SHIFT: begin
                // A restart leaves stale bits in shreg; the next N shifts overwrite them all.
                if (start) begin
                    abort_d = 1'b1;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q < DATA_CNT)
                        shreg_d = {serial_in, shreg_q[N-1:1]};
                    if (cnt_q == LAST_CNT) begin
                        commit  = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_SHIFT);
    end

`ifdef SIPO_PARITY_EN
    // The last sample is the parity bit itself; shreg already holds the full data word.
    assign wr_perr = (^shreg_q) ^ serial_in;
`else
    assign wr_perr = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

    sipo_out_buf #(.N(N)) u_out_buf (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (commit),
        .wr_data    (shreg_d),
        .wr_perr    (wr_perr),
        .out_ready  (out_ready),
        .data_out   (data_out),
        .out_valid  (out_valid),
        .parity_err (parity_err),
        .overrun    (overrun)
    );

    assign busy        = busy_q;
    assign frame_abort = abort_q;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Directed bench for sipo_frame_rx (N=4): vector table plus reset and parity sequences.
module tb_sipo_frame_rx;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         serial_in = 1'b0;
    logic         out_ready = 1'b0;
    logic [N-1:0] data_out;
    logic         out_valid, busy, frame_abort, overrun, parity_err;

    int errors = 0;
    int checks = 0;

    sipo_frame_rx #(.N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .serial_in   (serial_in),
        .out_ready   (out_ready),
        .data_out    (data_out),
        .out_valid   (out_valid),
        .busy        (busy),
        .frame_abort (frame_abort),
        .overrun     (overrun),
        .parity_err  (parity_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st, si, rdy;
        logic       v;
        logic [3:0] d;
        logic       b, ab, ov;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(logic st, logic si, logic rdy, logic v, logic [3:0] d,
                                logic b, logic ab, logic ov);
        vec_t r;
        r.st = st; r.si = si; r.rdy = rdy; r.v = v; r.d = d; r.b = b; r.ab = ab; r.ov = ov;
        tbl.push_back(r);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // {valid, data, busy, abort, overrun, parity_err}
    function automatic logic [8:0] outs();
        return {out_valid, data_out, busy, frame_abort, overrun, parity_err};
    endfunction

    task automatic send_frame(input logic [N-1:0] d, input logic par, input logic rdy);
        out_ready = rdy;
        start = 1'b1; serial_in = 1'b0;
        step();
        start = 1'b0;
        for (int i = 0; i < N; i++) begin
            serial_in = d[i];
            step();
        end
`ifdef SIPO_PARITY_EN
        serial_in = par;
        step();
`else
        if (par) serial_in = 1'b0;
`endif
        serial_in = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        #2;
        chk("reset_outs", 32'(outs()), 32'h0);
        step();
        chk("reset_held", 32'(outs()), 32'h0);
        #3 rst = 1'b1;
        step();
        chk("post_reset_idle", 32'(outs()), 32'h0);

`ifndef SIPO_PARITY_EN
        // basic frame 4'hA
        add(1,0,1, 0,4'h0,1,0,0);
        add(0,0,1, 0,4'h0,1,0,0);
        add(0,1,1, 0,4'h0,1,0,0);
        add(0,0,1, 0,4'h0,1,0,0);
        add(0,1,1, 1,4'hA,0,0,0);
        // back-to-back 4'h3 with 1-cycle gap
        add(1,0,1, 0,4'hA,1,0,0);
        add(0,1,1, 0,4'hA,1,0,0);
        add(0,1,1, 0,4'hA,1,0,0);
        add(0,0,1, 0,4'hA,1,0,0);
        add(0,0,1, 1,4'h3,0,0,0);
        add(0,0,1, 0,4'h3,0,0,0);
        // stall: 4'h5 then 4'hC dropped with overrun
        add(1,0,0, 0,4'h3,1,0,0);
        add(0,1,0, 0,4'h3,1,0,0);
        add(0,0,0, 0,4'h3,1,0,0);
        add(0,1,0, 0,4'h3,1,0,0);
        add(0,0,0, 1,4'h5,0,0,0);
        add(1,0,0, 1,4'h5,1,0,0);
        add(0,0,0, 1,4'h5,1,0,0);
        add(0,0,0, 1,4'h5,1,0,0);
        add(0,1,0, 1,4'h5,1,0,0);
        add(0,1,0, 1,4'h5,0,0,1);
        add(0,0,0, 1,4'h5,0,0,0);
        add(0,0,1, 0,4'h5,0,0,0);
        // abort after 2 bits, then 4'hF
        add(1,0,1, 0,4'h5,1,0,0);
        add(0,1,1, 0,4'h5,1,0,0);
        add(0,0,1, 0,4'h5,1,0,0);
        add(1,0,1, 0,4'h5,1,1,0);
        add(0,1,1, 0,4'h5,1,0,0);
        add(0,1,1, 0,4'h5,1,0,0);
        add(0,1,1, 0,4'h5,1,0,0);
        add(0,1,1, 1,4'hF,0,0,0);
        add(0,0,1, 0,4'hF,0,0,0);
        // start in the final-bit cycle: no commit, then 4'h6
        add(1,0,1, 0,4'hF,1,0,0);
        add(0,1,1, 0,4'hF,1,0,0);
        add(0,1,1, 0,4'hF,1,0,0);
        add(0,1,1, 0,4'hF,1,0,0);
        add(1,1,1, 0,4'hF,1,1,0);
        add(0,0,1, 0,4'hF,1,0,0);
        add(0,1,1, 0,4'hF,1,0,0);
        add(0,1,1, 0,4'hF,1,0,0);
        add(0,0,1, 1,4'h6,0,0,0);
        add(0,0,1, 0,4'h6,0,0,0);
        // full buffer drained on the commit edge: 4'h2 replaced by 4'h7, no overrun
        add(1,0,0, 0,4'h6,1,0,0);
        add(0,0,0, 0,4'h6,1,0,0);
        add(0,1,0, 0,4'h6,1,0,0);
        add(0,0,0, 0,4'h6,1,0,0);
        add(0,0,0, 1,4'h2,0,0,0);
        add(1,0,0, 1,4'h2,1,0,0);
        add(0,1,0, 1,4'h2,1,0,0);
        add(0,1,0, 1,4'h2,1,0,0);
        add(0,1,0, 1,4'h2,1,0,0);
        add(0,0,1, 1,4'h7,0,0,0);
        add(0,0,1, 0,4'h7,0,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            start = tbl[i].st; serial_in = tbl[i].si; out_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d", i), 32'(outs()),
                32'({tbl[i].v, tbl[i].d, tbl[i].b, tbl[i].ab, tbl[i].ov, 1'b0}));
        end
        start = 1'b0; serial_in = 1'b0;
`endif

        // ---------------- async reset mid-frame ----------------
        out_ready = 1'b1;
        start = 1'b1; step();
        start = 1'b0; serial_in = 1'b1; step();
        serial_in = 1'b0; step();
        chk("midframe_busy", 32'(busy), 32'h1);
        #2 rst = 1'b0;
        #1 chk("midframe_rst", 32'(outs()), 32'h0);
        #1 rst = 1'b1;
        step();
        chk("after_rst_idle", 32'(outs()), 32'h0);

        // ---------------- async reset mid-stall ----------------
        send_frame(4'h5, 1'b0, 1'b0);
        chk("stall_word", 32'({out_valid, data_out}), 32'h15);
        step();
        chk("stall_hold", 32'({out_valid, data_out}), 32'h15);
        #2 rst = 1'b0;
        #1 chk("stall_rst", 32'(outs()), 32'h0);
        #1 rst = 1'b1;
        step();

        // ---------------- clean frame after reset ----------------
        send_frame(4'h9, 1'b0, 1'b1);
`ifdef SIPO_PARITY_EN
        // even parity over 4'h9 is 0, so this parity bit is correct
        chk("clean_9", 32'(outs()), 32'({1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0}));
`else
        chk("clean_9", 32'(outs()), 32'({1'b1, 4'h9, 1'b0, 1'b0, 1'b0, 1'b0}));
`endif
        step();
        chk("clean_9_drain", 32'(out_valid), 32'h0);

`ifdef SIPO_PARITY_EN
        // 4'hB with correct parity: valid only after the parity-bit edge
        out_ready = 1'b1;
        start = 1'b1; step();
        start = 1'b0;
        serial_in = 1'b1; step();
        serial_in = 1'b1; step();
        serial_in = 1'b0; step();
        serial_in = 1'b1; step();
        chk("par_not_yet", 32'({out_valid, busy}), 32'h1);
        serial_in = 1'b1; step();
        chk("par_ok", 32'({out_valid, data_out, parity_err}), 32'({1'b1, 4'hB, 1'b0}));
        serial_in = 1'b0; step();
        chk("par_drain", 32'(out_valid), 32'h0);
        send_frame(4'hB, 1'b0, 1'b1);
        chk("par_bad", 32'({out_valid, data_out, parity_err}), 32'({1'b1, 4'hB, 1'b1}));
        step();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
